if_fetch_unit: RTL and testbench

Instruction-fetch front end. It owns the architectural PC, issues single-outstanding requests to instruction memory, and drives the pc/pc+4/instruction inputs of the IF/ID pipeline register. It honours the same stall signal (stage1_rewrite) and the branch/jump redirect that flushes IF/ID. Its output registers change only when IF/ID will capture them.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_hold_buffer.sv | 35 +++
 rtl/if_fetch_unit.sv | 158 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end and the IF/ID register.
//   fetch_state_e       : fetch controller states
//   RESET_PC_DEFAULT    : architectural PC after reset
//   BUBBLE_INST_DEFAULT : instruction word presented when no real fetch is valid
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding to imem, waiting for gnt
    WAIT  = 2'd1,  // granted, waiting for rvalid
    HOLD  = 2'd2,  // response parked in the hold buffer while IF/ID stalls
    DROP  = 2'd3   // response still owed for a redirected-away fetch
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0040_0000;
  localparam logic [31:0] BUBBLE_INST_DEFAULT = 32'h1111_1111;

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry pc/instruction buffer that parks a fetch response while IF/ID stalls.
//   clk, rst        : clock, synchronous active-high reset
//   clear           : drop the stored entry
//   load            : capture pc_in/inst_in (clear wins if both are set)
//   pc_in, inst_in  : entry to store
//   pc, inst        : stored entry
module if_hold_buffer
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  logic [31:0] pc_q, inst_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pc_q   <= '0;
      inst_q <= BUBBLE_INST_DEFAULT;
    end else if (load) begin
      pc_q   <= pc_in;
      inst_q <= inst_in;
    end
  end

  assign pc   = pc_q;
  assign inst = inst_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding imem requests
// and drives the pc/pc+4/instruction inputs of the IF/ID register.
//   clk, rst                    : clock, synchronous active-high reset
//   stage1_rewrite              : IF/ID stall; presented outputs hold
//   redirect_valid, redirect_pc : taken branch/jump (also flushes IF/ID)
//   imem_req, imem_addr         : fetch request, held until imem_gnt
//   imem_gnt, imem_rvalid, imem_rdata : memory handshake and response
//   pc_out, pc_add4_out, inst_out, if_valid : registered IF/ID inputs
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [31:0] BUBBLE_INST = BUBBLE_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stage1_rewrite,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] pc_add4_out,
  output logic [31:0] inst_out,
  output logic        if_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_out_q, pc_out_d, pc_add4_q, pc_add4_d, inst_q, inst_d;
  logic         valid_q, valid_d;

  logic         present;
  logic [31:0]  present_pc, present_inst;
  logic         buf_load, buf_clear;
  logic [31:0]  buf_pc, buf_inst;
  logic [31:0]  redirect_target;
  logic         unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  if_hold_buffer u_hold_buffer (
    .clk     (clk),
    .rst     (rst),
    .clear   (buf_clear),
    .load    (buf_load),
    .pc_in   (pc_q),
    .inst_in (imem_rdata),
    .pc      (buf_pc),
    .inst    (buf_inst)
  );

  // State register, PC and IF/ID-facing output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      pc_out_q  <= RESET_PC;
      pc_add4_q <= '0;
      inst_q    <= BUBBLE_INST;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_out_q  <= pc_out_d;
      pc_add4_q <= pc_add4_d;
      inst_q    <= inst_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state, next-PC and "instruction to present this cycle".
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    present      = 1'b0;
    present_pc   = pc_q;
    present_inst = imem_rdata;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_target;
      unique case (state_q)
        FETCH: state_d = imem_gnt ? DROP : FETCH;
        WAIT:  state_d = imem_rvalid ? FETCH : DROP;
        HOLD: begin
          state_d   = FETCH;
          buf_clear = 1'b1;
        end
        // A response landing on the redirect edge settles the owed beat.
        DROP:  state_d = imem_rvalid ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: if (imem_gnt) state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (stage1_rewrite) begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end else begin
              present = 1'b1;
              pc_d    = pc_q + 32'd4;
              state_d = FETCH;
            end
          end
        end
        HOLD: begin
          if (!stage1_rewrite) begin
            present      = 1'b1;
            present_pc   = buf_pc;
            present_inst = buf_inst;
            pc_d         = pc_q + 32'd4;
            state_d      = FETCH;
          end
        end
        DROP: if (imem_rvalid) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  // IF/ID output registers: redirect flushes, stall holds, otherwise load or bubble.
  always_comb begin
    pc_out_d  = pc_out_q;
    pc_add4_d = pc_add4_q;
    inst_d    = inst_q;
    valid_d   = valid_q;
    if (redirect_valid || (!stage1_rewrite && !present)) begin
      pc_out_d  = RESET_PC;
      pc_add4_d = '0;
      inst_d    = BUBBLE_INST;
      valid_d   = 1'b0;
    end else if (!stage1_rewrite) begin
      pc_out_d  = present_pc;
      pc_add4_d = present_pc + 32'd4;
      inst_d    = present_inst;
      valid_d   = 1'b1;
    end
  end

  // Request is gated by rst so it reads low during the reset cycle itself.
  always_comb begin
    imem_req  = (state_q == FETCH) && !rst;
    imem_addr = pc_q;
  end

  assign pc_out      = pc_out_q;
  assign pc_add4_out = pc_add4_q;
  assign inst_out    = inst_q;
  assign if_valid    = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] BUB = 32'h1111_1111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stage1_rewrite = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_out, pc_add4_out, inst_out;
  logic        if_valid;

  int vectors = 0;
  int errors  = 0;

  // Reference model: a fetch owed by memory, whether it must be discarded,
  // and a queue of parked responses.
  logic [31:0] m_pc = RPC;
  bit          m_out = 0;
  bit          m_disc = 0;
  logic [63:0] hq[$];
  logic [31:0] e_pc = RPC, e_add4 = '0, e_inst = BUB;
  logic        e_valid = 1'b0;

  // Memory-side bookkeeping for the random responder.
  bit mem_pend = 0;
  int mem_delay = 0;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stage1_rewrite (stage1_rewrite),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .pc_out         (pc_out),
    .pc_add4_out    (pc_add4_out),
    .inst_out       (inst_out),
    .if_valid       (if_valid)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, check request before the edge, advance the
  // model on the edge and check the registered outputs just after it.
  task automatic apply(input bit r, input bit s, input bit rd, input logic [31:0] rp,
                       input bit g, input bit v, input logic [31:0] data);
    logic exp_req, acc;
    bit got, pres;
    logic [31:0] ppc, pinst;
    rst = r; stage1_rewrite = s; redirect_valid = rd; redirect_pc = rp;
    imem_gnt = g; imem_rvalid = v; imem_rdata = data;
    #1;
    exp_req = !r && !m_out && (hq.size() == 0);
    vectors++;
    if (imem_req !== exp_req) begin
      errors++;
      $display("FAIL imem_req: got %b want %b at %0t", imem_req, exp_req, $time);
    end
    if (exp_req) begin
      vectors++;
      if (imem_addr !== m_pc) begin
        errors++;
        $display("FAIL imem_addr: got %h want %h at %0t", imem_addr, m_pc, $time);
      end
    end
    acc = imem_req && g;
    @(posedge clk);
    pres = 0; ppc = '0; pinst = '0;
    if (r) begin
      m_pc = RPC; m_out = 0; m_disc = 0; hq.delete();
      e_pc = RPC; e_add4 = '0; e_inst = BUB; e_valid = 1'b0;
    end else begin
      got = m_out && v;
      if (rd) begin
        m_pc = {rp[31:2], 2'b00};
        hq.delete();
        if (exp_req && g) begin m_out = 1; m_disc = 1; end
        else if (got) begin m_out = 0; m_disc = 0; end
        else if (m_out) m_disc = 1;
      end else begin
        if (exp_req && g) begin
          m_out = 1; m_disc = 0;
        end else if (got) begin
          m_out = 0;
          if (m_disc) m_disc = 0;
          else if (s) hq.push_back({m_pc, data});
          else begin pres = 1; ppc = m_pc; pinst = data; end
        end else if (hq.size() != 0 && !s) begin
          {ppc, pinst} = hq.pop_front();
          pres = 1;
        end
        if (pres) m_pc = ppc + 32'd4;
      end
      if (rd || (!s && !pres)) begin
        e_pc = RPC; e_add4 = '0; e_inst = BUB; e_valid = 1'b0;
      end else if (!s) begin
        e_pc = ppc; e_add4 = ppc + 32'd4; e_inst = pinst; e_valid = 1'b1;
      end
    end
    if (v) mem_pend = 0;
    if (acc) begin mem_pend = 1; mem_delay = $urandom_range(0, 2); end
    else if (mem_pend && mem_delay > 0) mem_delay--;
    #1;
    vectors += 4;
    if (pc_out !== e_pc) begin
      errors++; $display("FAIL pc_out: got %h want %h at %0t", pc_out, e_pc, $time);
    end
    if (pc_add4_out !== e_add4) begin
      errors++; $display("FAIL pc_add4_out: got %h want %h at %0t", pc_add4_out, e_add4, $time);
    end
    if (inst_out !== e_inst) begin
      errors++; $display("FAIL inst_out: got %h want %h at %0t", inst_out, e_inst, $time);
    end
    if (if_valid !== e_valid) begin
      errors++; $display("FAIL if_valid: got %b want %b at %0t", if_valid, e_valid, $time);
    end
  endtask

  task automatic test_reset();
    apply(1, 0, 0, '0, 0, 0, '0);
    apply(1, 0, 0, '0, 0, 0, '0);
    vectors++;
    if (pc_out !== RPC || pc_add4_out !== 32'h0 || inst_out !== BUB || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%h/%h/%b want %h/0/%h/0",
               pc_out, pc_add4_out, inst_out, if_valid, RPC, BUB);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      errors++;
      $display("FAIL reset_first_req: got %b/%h want 1/%h", imem_req, imem_addr, RPC);
    end
  endtask

  task automatic test_back_to_back();
    apply(1, 0, 0, '0, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, '0, 1, 0, '0);
      vectors++;
      if (if_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_gap_valid[%0d]: got %b want 0", i, if_valid);
      end
      apply(0, 0, 0, '0, 0, 1, 32'h1000 + i);
      vectors++;
      if (pc_out !== RPC + 4 * i || pc_add4_out !== RPC + 4 * i + 4 ||
          inst_out !== 32'h1000 + i || if_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_present[%0d]: got %h/%h/%h/%b want %h/%h/%h/1", i, pc_out,
                 pc_add4_out, inst_out, if_valid, RPC + 4 * i, RPC + 4 * i + 4, 32'h1000 + i);
      end
    end
  endtask

  task automatic test_stall_hold();
    apply(1, 0, 0, '0, 0, 0, '0);
    apply(0, 0, 0, '0, 1, 0, '0);
    apply(0, 0, 0, '0, 0, 1, 32'h0000_0013);
    apply(0, 1, 0, '0, 1, 0, '0);
    apply(0, 1, 0, '0, 0, 1, 32'h00A0_0093);
    apply(0, 1, 0, '0, 0, 0, '0);
    apply(0, 1, 0, '0, 0, 0, '0);
    vectors++;
    if (pc_out !== RPC || inst_out !== 32'h13 || if_valid !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_frozen: got %h/%h/%b req %b want %h/00000013/1 req 0",
               pc_out, inst_out, if_valid, imem_req, RPC);
    end
    apply(0, 0, 0, '0, 0, 0, '0);
    vectors++;
    if (pc_out !== 32'h0040_0004 || inst_out !== 32'h00A0_0093 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got %h/%h/%b want 00400004/00a00093/1",
               pc_out, inst_out, if_valid);
    end
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0008) begin
      errors++;
      $display("FAIL stall_next_addr: got %b/%h want 1/00400008", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    apply(0, 0, 0, '0, 1, 0, '0);
    apply(0, 0, 1, 32'h0040_0103, 0, 0, '0);
    vectors++;
    if (inst_out !== BUB || if_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_wait_bubble: got %h/%b req %b want %h/0 req 0",
               inst_out, if_valid, imem_req, BUB);
    end
    apply(0, 0, 0, '0, 0, 1, 32'hDEAD_BEEF);
    vectors++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin
      errors++;
      $display("FAIL redir_wait_drop: got valid %b req %b addr %h want 0/1/00400100",
               if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_stall();
    apply(0, 0, 0, '0, 1, 0, '0);
    apply(0, 0, 0, '0, 0, 1, 32'h0000_0055);
    apply(0, 1, 1, 32'h0040_0200, 0, 0, '0);
    vectors++;
    if (inst_out !== BUB || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_over_stall: got %h/%b want %h/0", inst_out, if_valid, BUB);
    end
  endtask

  task automatic test_wrap();
    apply(0, 0, 1, 32'hFFFF_FFFC, 0, 0, '0);
    apply(0, 0, 0, '0, 1, 0, '0);
    apply(0, 0, 0, '0, 0, 1, 32'h0000_0077);
    vectors++;
    if (pc_out !== 32'hFFFF_FFFC || pc_add4_out !== 32'h0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap: got pc %h add4 %h addr %h want fffffffc/0/0",
               pc_out, pc_add4_out, imem_addr);
    end
  endtask

  task automatic test_reset_wait();
    apply(0, 0, 0, '0, 1, 0, '0);
    apply(1, 0, 0, '0, 0, 0, '0);
    vectors++;
    if (pc_out !== RPC || pc_add4_out !== 32'h0 || inst_out !== BUB || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_values: got %h/%h/%h/%b", pc_out, pc_add4_out, inst_out, if_valid);
    end
    apply(0, 0, 0, '0, 0, 1, 32'h0BAD_0BAD);
    vectors++;
    if (if_valid !== 1'b0 || inst_out !== BUB || imem_req !== 1'b1 || imem_addr !== RPC) begin
      errors++;
      $display("FAIL reset_wait_ignore: got valid %b inst %h req %b addr %h",
               if_valid, inst_out, imem_req, imem_addr);
    end
  endtask

  task automatic test_random();
    bit r, s, rd, g, v;
    logic [31:0] rp;
    apply(1, 0, 0, '0, 0, 0, '0);
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 6);
      rp = $urandom;
      if ($urandom_range(0, 3) == 0) rp = rp | 32'hFFFF_FFF0;
      g  = imem_req && !mem_pend && ($urandom_range(0, 99) < 60);
      v  = mem_pend && (mem_delay == 0) && ($urandom_range(0, 99) < 70);
      apply(r, s, rd, rp, g, v, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_stall();
    test_wrap();
    test_reset_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
